status_reg_stacked: RTL and testbench
=====================================

Name: status_reg_stacked

Overview:
- Next-generation CPU status register with fields {alu_status, imask, mode}, widths set by parameters.
- Adds a hardware LIFO of saved status words for nested trap entry/return, plus sticky overflow/underflow fault flags.
- Drives two tri-state register-file buses (a, b) and exposes its current value to the control unit and ALU.

Parameters:
ALU_STATUS_WIDTH, 4, width of the alu_status field (N/Z/C/V in the default build)
IMASK_WIDTH, 1, number of interrupt-mask bits
STACK_DEPTH, 4, number of saved status words, >= 1
W (localparam), ALU_STATUS_WIDTH+IMASK_WIDTH+1, status word width; layout MSB..LSB = alu_status, imask, mode

Ports:
clk  in  1  clock, rising edge active
rst  in  1  reset; one clock; reset is asynchronous and active-low
a  inout(tri)  W  bus A; driven with value when oe_a, else Z
b  inout(tri)  W  bus B; driven with value when oe_b, else Z
in  in  W  bus write data
oe_a  in  1  drive bus A
oe_b  in  1  drive bus B
ld  in  1  whole-word load from in (privilege-filtered)
alu_status_in  in  ALU_STATUS_WIDTH  ALU flags
ld_alu_status  in  1  load alu_status field
imask_in  in  IMASK_WIDTH  mask value from control unit
ld_imask  in  1  load imask field
mode_in  in  1  cpu_mode_e value
ld_mode  in  1  load mode field
trap_enter  in  1  push value, enter supervisor, mask all interrupts
trap_return  in  1  pop saved word into value
clr_fault  in  1  clear sticky fault flags
value  out  W  current status word
depth  out  $clog2(STACK_DEPTH+1)  number of saved words
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst low, async): alu_status=0, imask=0, mode=SUPERVISOR, depth=0, overflow=0, underflow=0. Stack contents are don't-care. a and b are Z whenever oe is low.
- All state changes occur on the rising clk edge. value and depth are visible 1 cycle after the request. Bus outputs are combinational from value.
- Per-cycle priority: trap_enter > trap_return > normal loads. A lower-priority request in the same cycle is ignored entirely.
- trap_enter:
  - If depth<STACK_DEPTH: push value, depth++.
  - Then value.mode=SUPERVISOR, value.imask=all ones; alu_status unchanged.
  - If full: no push, depth unchanged, overflow<=1, mode/imask update still applied.
- trap_return:
  - If depth>0: value<=top entry, depth--.
  - If empty: value unchanged, underflow<=1.
- Normal loads (no trap request):
  - ld in SUPERVISOR mode: all fields take in.
  - ld in USER mode: only alu_status takes in. imask and mode are retained (privilege filter).
  - ld_alu_status / ld_imask / ld_mode: load their field from the dedicated input, unrestricted by mode. Each overrides the same field from ld when asserted in the same cycle.
- Privilege is judged on the mode before the edge.
- clr_fault clears both flags. If a new fault arises in the same cycle, set wins.
- Simultaneous oe_a and oe_b: both buses are driven.

Decomposition:
- reg_pkg:
  - Keeps cpu_mode_e (USER, SUPERVISOR).
  - Adds the default-width status_t/alu_status_t typedefs.
  - Adds a STATUS_RESET constant and field-offset localparams.
  - The module slices fields by offset so non-default widths work.
- Sub-module status_lifo: parametrised W x STACK_DEPTH array plus pointer.
  - Inputs: push, pop, din.
  - Outputs: dout, depth, full, empty.
  - Reset is on the pointer only.

Test Plan:
- Reset low mid-run after 2 pushes -> value=SUPERVISOR/imask 0/alu 0, depth=0, flags 0, immediately without a clock edge.
- Supervisor ld in=alu 1010, imask 1, SUPERVISOR, oe_a then oe_b -> each bus equals the word, the other bus is Z. Then USER mode, ld with imask inverted and mode=SUPERVISOR -> alu updated, imask/mode unchanged.
- Nested traps, default depth 4: value V0, trap_enter, change alu, trap_enter -> depth=2, mode=SUPERVISOR, imask=1. trap_return twice -> value restored to the intermediate word, then V0, depth=0.
- Push 5 times with depth 4 -> overflow=1, depth=4. 4 pops return the last 4 pushed words in LIFO order. A 5th pop -> underflow=1, value unchanged. clr_fault -> both flags 0.
- trap_enter+trap_return+ld asserted together -> only the push occurs. ld_mode with ld in USER -> mode follows mode_in.
- Rebuild with ALU_STATUS_WIDTH=5, IMASK_WIDTH=3, STACK_DEPTH=1 -> W=9, trap_enter sets imask=111, second push flags overflow.

Source files
------------

// File: rtl/status_reg_stacked_pkg.sv
`default_nettype none
// ============================================================================
// Module      : status_reg_stacked_pkg
// Description : Shared types and constants for the stacked CPU status register.
// Revision    : 1.0 - initial release
// ============================================================================
package status_reg_stacked_pkg;

    typedef enum logic {
        USER       = 1'b0,
        SUPERVISOR = 1'b1
    } cpu_mode_e;

    localparam int DEF_ALU_STATUS_WIDTH = 4;
    localparam int DEF_IMASK_WIDTH      = 1;

    typedef logic [DEF_ALU_STATUS_WIDTH-1:0] alu_status_t;

    typedef struct packed {
        alu_status_t                  alu_status;
        logic [DEF_IMASK_WIDTH-1:0]   imask;
        cpu_mode_e                    mode;
    } status_t;

    // Field offsets within the status word (LSB upward: mode, imask, alu_status).
    localparam int MODE_OFS  = 0;
    localparam int IMASK_OFS = 1;

    localparam status_t STATUS_RESET = '{alu_status: '0, imask: '0, mode: SUPERVISOR};

    function automatic int alu_status_ofs(input int imask_width);
        return IMASK_OFS + imask_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_reg_stacked_lifo.sv
`default_nettype none
// ============================================================================
// Module      : status_lifo
// Description : W x STACK_DEPTH LIFO of saved status words; only the pointer resets.
// Revision    : 1.0 - initial release
// ============================================================================
module status_lifo #(
    parameter  int W           = 6,
    parameter  int STACK_DEPTH = 4,
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [DW-1:0] depth,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] ptr_q;
    logic [W-1:0]  mem_q [STACK_DEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (ptr_q == DW'(STACK_DEPTH));
    assign empty   = (ptr_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign depth   = ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (push_ok) begin
            ptr_q <= ptr_q + DW'(1);
        end else if (pop_ok) begin
            ptr_q <= ptr_q - DW'(1);
        end
    end

    // Storage is deliberately unreset: entries above the pointer are never observed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push_ok && (ptr_q == DW'(i))) begin
                mem_q[i] <= din;
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (ptr_q == DW'(i + 1)) begin
                dout = mem_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/status_reg_stacked.sv
`default_nettype none
// ============================================================================
// Module      : status_reg_stacked
// Description : CPU status register {alu_status, imask, mode} with trap LIFO,
//               sticky overflow/underflow flags and two tri-state bus drivers.
// Revision    : 1.0 - initial release
// ============================================================================
module status_reg_stacked
    import status_reg_stacked_pkg::*;
#(
    parameter  int ALU_STATUS_WIDTH = 4,
    parameter  int IMASK_WIDTH      = 1,
    parameter  int STACK_DEPTH      = 4,
    localparam int W                = ALU_STATUS_WIDTH + IMASK_WIDTH + 1,
    localparam int DW               = $clog2(STACK_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    inout  tri   [W-1:0]                a,
    inout  tri   [W-1:0]                b,
    input  logic [W-1:0]                in,
    input  logic                        oe_a,
    input  logic                        oe_b,
    input  logic                        ld,
    input  logic [ALU_STATUS_WIDTH-1:0] alu_status_in,
    input  logic                        ld_alu_status,
    input  logic [IMASK_WIDTH-1:0]      imask_in,
    input  logic                        ld_imask,
    input  logic                        mode_in,
    input  logic                        ld_mode,
    input  logic                        trap_enter,
    input  logic                        trap_return,
    input  logic                        clr_fault,
    output logic [W-1:0]                value,
    output logic [DW-1:0]               depth,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ALU_OFS = alu_status_ofs(IMASK_WIDTH);

    // Every non-mode bit of the reset word is zero, so resizing keeps it valid
    // for any field widths.
    localparam logic [W-1:0] RESET_WORD = W'(STATUS_RESET);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;
    logic         ovf_q;
    logic         ovf_d;
    logic         unf_q;
    logic         unf_d;

    cpu_mode_e    cur_mode;
    logic         lifo_push;
    logic         lifo_pop;
    logic [W-1:0] lifo_dout;
    logic         lifo_full;
    logic         lifo_empty;

    assign cur_mode  = cpu_mode_e'(value_q[MODE_OFS]);
    assign lifo_push = trap_enter;
    assign lifo_pop  = ~trap_enter & trap_return;

    status_lifo #(
        .W           (W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (lifo_push),
        .pop   (lifo_pop),
        .din   (value_q),
        .dout  (lifo_dout),
        .depth (depth),
        .full  (lifo_full),
        .empty (lifo_empty)
    );

    always_comb begin
        value_d = value_q;
        if (trap_enter) begin
            value_d[MODE_OFS]                  = SUPERVISOR;
            value_d[IMASK_OFS +: IMASK_WIDTH]  = '1;
        end else if (trap_return) begin
            if (!lifo_empty) begin
                value_d = lifo_dout;
            end
        end else begin
            // A user-mode whole-word write may only touch the ALU flags.
            if (ld) begin
                if (cur_mode == SUPERVISOR) begin
                    value_d = in;
                end else begin
                    value_d[ALU_OFS +: ALU_STATUS_WIDTH] = in[ALU_OFS +: ALU_STATUS_WIDTH];
                end
            end
            if (ld_alu_status) begin
                value_d[ALU_OFS +: ALU_STATUS_WIDTH] = alu_status_in;
            end
            if (ld_imask) begin
                value_d[IMASK_OFS +: IMASK_WIDTH] = imask_in;
            end
            if (ld_mode) begin
                value_d[MODE_OFS] = mode_in;
            end
        end
    end

    always_comb begin
        ovf_d = (ovf_q & ~clr_fault) | (trap_enter & lifo_full);
        unf_d = (unf_q & ~clr_fault) | (lifo_pop & lifo_empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= RESET_WORD;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign value     = value_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    assign a = oe_a ? value_q : {W{1'bz}};
    assign b = oe_b ? value_q : {W{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_status_reg_stacked.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_reg_stacked
// Description : Self-checking bench: field-level reference model plus directed
//               literal checks and a small non-default build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_reg_stacked;

    localparam int W  = 6;
    localparam int DP = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in = '0;
    logic         oe_a = 1'b0, oe_b = 1'b0, ld = 1'b0;
    logic [3:0]   alu_status_in = '0;
    logic         ld_alu_status = 1'b0, imask_in = 1'b0, ld_imask = 1'b0;
    logic         mode_in = 1'b0, ld_mode = 1'b0;
    logic         trap_enter = 1'b0, trap_return = 1'b0, clr_fault = 1'b0;
    logic [W-1:0] pat_a = 6'h15, pat_b = 6'h2A;
    wire  [W-1:0] a, b;
    logic [W-1:0] value;
    logic [2:0]   depth;
    logic         overflow, underflow;

    // Bench-side drivers occupy each bus whenever the DUT should be released.
    assign a = oe_a ? {W{1'bz}} : pat_a;
    assign b = oe_b ? {W{1'bz}} : pat_b;

    status_reg_stacked #(.ALU_STATUS_WIDTH(4), .IMASK_WIDTH(1), .STACK_DEPTH(DP)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in(in), .oe_a(oe_a), .oe_b(oe_b), .ld(ld),
        .alu_status_in(alu_status_in), .ld_alu_status(ld_alu_status),
        .imask_in(imask_in), .ld_imask(ld_imask), .mode_in(mode_in), .ld_mode(ld_mode),
        .trap_enter(trap_enter), .trap_return(trap_return), .clr_fault(clr_fault),
        .value(value), .depth(depth), .overflow(overflow), .underflow(underflow)
    );

    logic       te1 = 1'b0;
    wire  [8:0] a1, b1;
    logic [8:0] value1;
    logic [0:0] depth1;
    logic       ovf1, unf1;

    status_reg_stacked #(.ALU_STATUS_WIDTH(5), .IMASK_WIDTH(3), .STACK_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in(9'h0), .oe_a(1'b0), .oe_b(1'b0), .ld(1'b0),
        .alu_status_in(5'h0), .ld_alu_status(1'b0), .imask_in(3'h0), .ld_imask(1'b0),
        .mode_in(1'b0), .ld_mode(1'b0), .trap_enter(te1), .trap_return(1'b0),
        .clr_fault(1'b0), .value(value1), .depth(depth1), .overflow(ovf1), .underflow(unf1)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: fields held separately, saved words in a queue.
    logic [3:0]   m_alu   = 4'h0;
    logic         m_imask = 1'b0;
    logic         m_mode  = 1'b1;
    logic         m_ovf   = 1'b0;
    logic         m_unf   = 1'b0;
    logic [W-1:0] m_stack[$];

    function automatic logic [W-1:0] m_word();
        return {m_alu, m_imask, m_mode};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_alu = 4'h0; m_imask = 1'b0; m_mode = 1'b1;
            m_ovf = 1'b0; m_unf = 1'b0;
            m_stack.delete();
        end else begin
            logic was_sup;
            logic [W-1:0] w;
            was_sup = m_mode;
            if (clr_fault) begin m_ovf = 1'b0; m_unf = 1'b0; end
            if (trap_enter) begin
                if (m_stack.size() < DP) m_stack.push_back(m_word());
                else m_ovf = 1'b1;
                m_mode = 1'b1;
                m_imask = 1'b1;
            end else if (trap_return) begin
                if (m_stack.size() > 0) begin
                    w = m_stack.pop_back();
                    m_alu = w[5:2]; m_imask = w[1]; m_mode = w[0];
                end else m_unf = 1'b1;
            end else begin
                if (ld) begin
                    m_alu = in[5:2];
                    if (was_sup) begin m_imask = in[1]; m_mode = in[0]; end
                end
                if (ld_alu_status) m_alu = alu_status_in;
                if (ld_imask) m_imask = imask_in;
                if (ld_mode) m_mode = mode_in;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("value", value, m_word());
            chk("depth", depth, m_stack.size());
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
            chk("bus_a", a, oe_a ? m_word() : pat_a);
            chk("bus_b", b, oe_b ? m_word() : pat_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        pat_a = W'($urandom);
        pat_b = W'($urandom);
    endtask

    task automatic idle();
        ld = 0; ld_alu_status = 0; ld_imask = 0; ld_mode = 0;
        trap_enter = 0; trap_return = 0; clr_fault = 0; oe_a = 0; oe_b = 0;
    endtask

    logic [W-1:0] pops [4];

    initial begin
        pops[0] = 6'h0F; pops[1] = 6'h0B; pops[2] = 6'h07; pops[3] = 6'h02;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_value", value, 6'h01);
        chk("reset_depth", depth, 0);
        chk("reset_flags", {overflow, underflow}, 0);
        chk("reset_bus_a", a, pat_a);
        chk("reset_value_w9", value1, 9'h001);
        @(posedge clk); #2;
        rst = 1'b1;
        chk_en = 1'b1;

        // Supervisor whole-word load, then privilege filter in user mode.
        in = 6'h2B; ld = 1; oe_a = 1; step(); idle();
        chk("sup_ld", value, 6'h2B);
        oe_b = 1; step(); idle();
        mode_in = 0; ld_mode = 1; step(); idle();
        chk("to_user", value, 6'h2A);
        in = 6'h15; ld = 1; step(); idle();
        chk("user_ld", value, 6'h16);

        // Nested traps and returns.
        trap_enter = 1; step(); idle();
        chk("trap1", value, 6'h17);
        alu_status_in = 4'hC; ld_alu_status = 1; step(); idle();
        trap_enter = 1; step(); idle();
        chk("trap2_depth", depth, 2);
        chk("trap2_value", value, 6'h33);
        trap_return = 1; step(); idle();
        chk("ret1", value, 6'h33);
        trap_return = 1; step(); idle();
        chk("ret2", value, 6'h16);
        chk("ret2_depth", depth, 0);

        // Fill past the top, then drain past the bottom.
        for (int k = 0; k < 5; k++) begin
            alu_status_in = 4'(k); ld_alu_status = 1; step(); idle();
            trap_enter = 1; step(); idle();
        end
        chk("full_ovf", overflow, 1);
        chk("full_depth", depth, 4);
        chk("full_value", value, 6'h13);
        for (int k = 0; k < 4; k++) begin
            trap_return = 1; step(); idle();
            chk("lifo_pop", value, pops[k]);
        end
        trap_return = 1; step(); idle();
        chk("pop_empty_unf", underflow, 1);
        chk("pop_empty_value", value, 6'h02);
        clr_fault = 1; step(); idle();
        chk("clr_fault", {overflow, underflow}, 0);

        // Priority: only the push happens.
        trap_enter = 1; trap_return = 1; ld = 1; in = 6'h00; step(); idle();
        chk("prio_depth", depth, 1);
        chk("prio_value", value, 6'h03);
        mode_in = 0; ld_mode = 1; step(); idle();
        in = 6'h3F; ld = 1; ld_mode = 1; mode_in = 0; step(); idle();
        chk("user_ld_mode", value, 6'h3E);

        // Asynchronous reset between clock edges.
        trap_enter = 1; step(); step(); idle();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("async_value", value, 6'h01);
        chk("async_depth", depth, 0);
        chk("async_flags", {overflow, underflow}, 0);
        @(posedge clk); #2;
        rst = 1'b1;

        // Non-default build: 9-bit word, single-entry stack.
        te1 = 1; step();
        chk("w9_push_value", value1, 9'h00F);
        chk("w9_push_depth", depth1, 1);
        chk("w9_push_ovf", ovf1, 0);
        step(); te1 = 0;
        chk("w9_ovf", ovf1, 1);
        chk("w9_depth", depth1, 1);
        chk("w9_value", value1, 9'h00F);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            trap_enter    = ($urandom % 8) == 0;
            trap_return   = ($urandom % 7) == 0;
            ld            = ($urandom % 3) == 0;
            ld_alu_status = ($urandom % 6) == 0;
            ld_imask      = ($urandom % 6) == 0;
            ld_mode       = ($urandom % 5) == 0;
            clr_fault     = ($urandom % 10) == 0;
            oe_a          = 1'($urandom);
            oe_b          = 1'($urandom);
            in            = W'($urandom);
            alu_status_in = 4'($urandom);
            imask_in      = 1'($urandom);
            mode_in       = 1'($urandom);
            step();
        end
        idle();
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
